// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter
//   Round-robin arbiter that lets NREQ byte producers share one UART TX FIFO.
//   A requester that holds lock keeps the grant across consecutive bytes
//   (one byte per 2 cycles). Without lock, ownership is re-arbitrated after
//   every byte (one byte per 3 cycles). A locked owner that goes quiet for
//   TIMEOUT cycles is forcibly released.
//
// Ports
//   clk, rst_n      clock, asynchronous active-low reset
//   req[NREQ]       per-requester byte valid
//   lock[NREQ]      per-requester keep-grant request
//   data            requester i byte at [i*DATA_WIDTH +: DATA_WIDTH]
//   ack[NREQ]       one-cycle pulse to the requester whose byte was pushed
//   grant[NREQ]     one-hot current owner, zero when no owner
//   tx_byte         registered byte to the TX FIFO
//   transmit        registered one-cycle push strobe to the TX FIFO
//   tx_fifo_full    TX FIFO full flag; the owner stalls while it is high
//   timeout_evt     one-cycle pulse when a lock is forcibly released
module uart_tx_arbiter #(
  parameter int NREQ       = 4,
  parameter int DATA_WIDTH = 8,
  parameter int TIMEOUT    = 255
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [NREQ-1:0]            req,
  input  logic [NREQ-1:0]            lock,
  input  logic [NREQ*DATA_WIDTH-1:0] data,
  output logic [NREQ-1:0]            ack,
  output logic [NREQ-1:0]            grant,
  output logic [DATA_WIDTH-1:0]      tx_byte,
  output logic                       transmit,
  input  logic                       tx_fifo_full,
  output logic                       timeout_evt
);

  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic [1:0] {IDLE, OWN, WAIT} state_t;

  state_t                       state, state_nxt;
  logic [IW-1:0]                owner, owner_nxt;
  logic [IW-1:0]                last_owner, last_owner_nxt;
  logic [7:0]                   hold_cnt, hold_nxt;
  logic [NREQ-1:0]              grant_nxt, ack_nxt;
  logic                         transmit_nxt, timeout_nxt;
  logic [DATA_WIDTH-1:0]        tx_byte_nxt;

  // Per-lane view of the flat data bus.
  logic [NREQ-1:0][DATA_WIDTH-1:0] lane_data;

  for (genvar g = 0; g < NREQ; g++) begin : g_lane
    assign lane_data[g] = data[g*DATA_WIDTH +: DATA_WIDTH];
  end

  // Round-robin pick: scan from last_owner+1 and wrap, so the requester
  // served most recently has the lowest priority.
  logic          pick_vld;
  logic [IW-1:0] pick_idx;
  logic [IW-1:0] cand;

  always_comb begin
    pick_vld = 1'b0;
    pick_idx = '0;
    cand     = '0;
    for (int k = 1; k <= NREQ; k++) begin
      cand = IW'((int'(last_owner) + k) % NREQ);
      if (!pick_vld && req[cand]) begin
        pick_vld = 1'b1;
        pick_idx = cand;
      end
    end
  end

  logic [NREQ-1:0] pick_1hot;
  assign pick_1hot = {{(NREQ-1){1'b0}}, 1'b1} << pick_idx;

  // Next-state and registered-output logic.
  always_comb begin
    state_nxt      = state;
    owner_nxt      = owner;
    last_owner_nxt = last_owner;
    hold_nxt       = hold_cnt;
    grant_nxt      = grant;
    ack_nxt        = '0;
    transmit_nxt   = 1'b0;
    timeout_nxt    = 1'b0;
    tx_byte_nxt    = tx_byte;
    case (state)
      IDLE: begin
        grant_nxt = '0;
        if (pick_vld) begin
          owner_nxt = pick_idx;
          grant_nxt = pick_1hot;
          hold_nxt  = '0;
          state_nxt = OWN;
        end
      end
      OWN: begin
        if (req[owner]) begin
          // While the FIFO is full the owner just waits; no rotation.
          if (!tx_fifo_full) begin
            tx_byte_nxt    = lane_data[owner];
            transmit_nxt   = 1'b1;
            ack_nxt        = grant;
            last_owner_nxt = owner;
            hold_nxt       = '0;
            state_nxt      = WAIT;
          end
        end else if (!lock[owner]) begin
          last_owner_nxt = owner;
          grant_nxt      = '0;
          state_nxt      = IDLE;
        end else begin
          hold_nxt = hold_cnt + 8'd1;
          if (hold_cnt + 8'd1 >= 8'(TIMEOUT)) begin
            timeout_nxt    = 1'b1;
            last_owner_nxt = owner;
            grant_nxt      = '0;
            state_nxt      = IDLE;
          end
        end
      end
      WAIT: begin
        // Ack cycle: requester updates req/data/lock before it ends.
        if (lock[owner]) begin
          hold_nxt  = '0;
          state_nxt = OWN;
        end else begin
          grant_nxt = '0;
          state_nxt = IDLE;
        end
      end
      default: begin
        grant_nxt = '0;
        state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      owner       <= '0;
      last_owner  <= IW'(NREQ-1);
      hold_cnt    <= '0;
      grant       <= '0;
      ack         <= '0;
      transmit    <= 1'b0;
      timeout_evt <= 1'b0;
      tx_byte     <= '0;
    end else begin
      state       <= state_nxt;
      owner       <= owner_nxt;
      last_owner  <= last_owner_nxt;
      hold_cnt    <= hold_nxt;
      grant       <= grant_nxt;
      ack         <= ack_nxt;
      transmit    <= transmit_nxt;
      timeout_evt <= timeout_nxt;
      tx_byte     <= tx_byte_nxt;
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
module tb_uart_tx_arbiter;
  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  req, lock, ack, grant;
  logic [31:0] data;
  logic [7:0]  tx_byte;
  logic        transmit, tx_fifo_full, timeout_evt;

  always #5 clk = ~clk;

  uart_tx_arbiter #(.NREQ(4), .DATA_WIDTH(8), .TIMEOUT(5)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .lock(lock), .data(data),
    .ack(ack), .grant(grant), .tx_byte(tx_byte), .transmit(transmit),
    .tx_fifo_full(tx_fifo_full), .timeout_evt(timeout_evt)
  );

  int errs = 0, checks = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Requester model: per-requester byte queue, pops on ack.
  logic [7:0] rbuf [4][16];
  int         rhead [4];
  int         rtail [4];
  logic [3:0] lock_en, hold_lock;

  task automatic drive();
    for (int i = 0; i < 4; i++) begin
      req[i]        = (rhead[i] != rtail[i]);
      data[i*8 +: 8] = req[i] ? rbuf[i][rhead[i]] : 8'h00;
      lock[i]       = (lock_en[i] && req[i]) || hold_lock[i];
    end
  endtask

  task automatic load(input int r, input logic [7:0] b);
    rbuf[r][rtail[r]] = b;
    rtail[r]++;
  endtask

  // Scoreboard of {ack mask, byte}.
  logic [11:0] sb[$];
  logic [11:0] sb_e;
  int          txc [64];
  int          ntx = 0;
  int          tocyc = 0, nto = 0;

  task automatic sb_push(input int r, input logic [7:0] b);
    logic [3:0] m;
    m = 4'b0001 << r;
    sb.push_back({m, b});
  endtask

  always @(negedge clk) begin
    chk("grant_1hot", 32'($onehot0(grant)), 1);
    chk("ack_only_tx", 32'((ack != 4'b0) && !transmit), 0);
    if (transmit) begin
      if (ntx < 64) txc[ntx] = cyc;
      ntx++;
      if (sb.size() == 0) chk("unexp_tx", {24'h0, tx_byte}, 32'hffff_ffff);
      else begin
        sb_e = sb.pop_front();
        chk("tx_byte", tx_byte, sb_e[7:0]);
        chk("ack", ack, sb_e[11:8]);
      end
    end
    if (timeout_evt) begin
      tocyc = cyc;
      nto++;
    end
    for (int i = 0; i < 4; i++)
      if (ack[i] && rhead[i] != rtail[i]) rhead[i]++;
    drive();
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic wait_sb(input int budget);
    int n;
    n = 0;
    while (sb.size() != 0 && n < budget) begin
      tick();
      n++;
    end
    if (sb.size() != 0) chk("sb_drain", sb.size(), 0);
    repeat (2) tick();
  endtask

  task automatic wait_tx(input int n0, input int budget);
    int n;
    n = 0;
    while (ntx <= n0 && n < budget) begin
      tick();
      n++;
    end
    if (ntx <= n0) chk("tx_wait", 0, 1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int c0, n0, t, m, k;
    rst_n = 1'b0; lock_en = '0; hold_lock = '0; tx_fifo_full = 1'b0;
    drive();
    repeat (3) tick();
    chk("rst_grant", grant, 0);
    chk("rst_ack", ack, 0);
    chk("rst_transmit", transmit, 0);
    chk("rst_tx_byte", tx_byte, 0);
    chk("rst_timeout", timeout_evt, 0);
    rst_n = 1'b1;
    tick();

    // All four request, unlocked: strict rotation, 3 cycles apart.
    c0 = cyc; n0 = ntx;
    for (int i = 0; i < 4; i++) begin
      load(i, 8'h10 + 8'(i));
      sb_push(i, 8'h10 + 8'(i));
    end
    drive();
    wait_sb(60);
    chk("latency", txc[n0] - c0, 2);
    for (int i = 1; i < 4; i++) chk("gap_unlocked", txc[n0+i] - txc[n0+i-1], 3);

    // Move last_owner to 1, then locked burst from 2 while 0 waits.
    load(1, 8'h21); sb_push(1, 8'h21); drive();
    wait_sb(30);
    lock_en = 4'b0100; n0 = ntx;
    load(0, 8'h55);
    for (int i = 0; i < 4; i++) begin
      load(2, 8'hA0 + 8'(i));
      sb_push(2, 8'hA0 + 8'(i));
    end
    sb_push(0, 8'h55);
    drive();
    wait_sb(80);
    for (int i = 1; i < 4; i++) chk("gap_locked", txc[n0+i] - txc[n0+i-1], 2);
    lock_en = '0; drive();

    // FIFO full stall.
    tx_fifo_full = 1'b1; n0 = ntx;
    load(1, 8'h77); sb_push(1, 8'h77); drive();
    repeat (12) tick();
    chk("full_no_tx", ntx - n0, 0);
    chk("full_grant", grant, 4'b0010);
    c0 = cyc;
    tx_fifo_full = 1'b0;
    wait_tx(n0, 20);
    chk("full_release", txc[n0] - c0, 1);
    wait_sb(20);

    // Lock timeout: requester 3 holds lock with no data.
    hold_lock = 4'b1000; n0 = ntx;
    load(3, 8'h33); sb_push(3, 8'h33); sb_push(1, 8'h45); drive();
    wait_tx(n0, 20);
    t = txc[n0];
    load(1, 8'h45); drive();
    m = nto; k = 0;
    while (nto == m && k < 20) begin
      tick();
      k++;
    end
    chk("to_seen", nto - m, 1);
    chk("to_delay", tocyc - t, 6);
    chk("to_grant_clr", grant, 0);
    hold_lock = '0; drive();
    tick();
    chk("to_pulse_1cyc", timeout_evt, 0);
    chk("to_next_grant", grant, 4'b0010);
    wait_sb(30);

    // Reset during the WAIT cycle of a push from requester 2.
    n0 = ntx;
    load(0, 8'hB0); load(2, 8'hB2); load(3, 8'hB3);
    sb_push(2, 8'hB2); sb_push(0, 8'hB0); sb_push(3, 8'hB3);
    drive();
    wait_tx(n0, 20);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_transmit", transmit, 0);
    chk("mid_rst_ack", ack, 0);
    chk("mid_rst_grant", grant, 0);
    chk("mid_rst_tx_byte", tx_byte, 0);
    chk("mid_rst_timeout", timeout_evt, 0);
    repeat (2) tick();
    rst_n = 1'b1;
    k = 0;
    while (grant == 4'b0 && k < 10) begin
      tick();
      k++;
    end
    chk("rst_first_grant", grant, 4'b0001);
    wait_sb(60);

    chk("sb_empty", sb.size(), 0);
    chk("to_count", nto, 1);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule

// File: doc/uart_tx_arbiter.md
UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

Interface
REQ-001 SHALL have parameter NREQ, default 4, meaning number of requesters (2..8).
REQ-002 SHALL have parameter DATA_WIDTH, default 8, meaning byte width pushed to the UART TX FIFO.
REQ-003 SHALL have parameter TIMEOUT, default 255, meaning idle cycles a locked owner may hold the grant with req low (1..255).
REQ-004 SHALL have port clk  input  1  single clock, all state on rising edge.
REQ-005 SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-006 SHALL have port req  input  NREQ  per-requester byte-valid request.
REQ-007 SHALL have port lock  input  NREQ  per-requester hold-grant across consecutive bytes.
REQ-008 SHALL have port data  input  NREQ*DATA_WIDTH  requester i byte at bits [i*DATA_WIDTH +: DATA_WIDTH].
REQ-009 SHALL have port ack  output  NREQ  one-cycle pulse to requester whose byte was pushed.
REQ-010 SHALL have port grant  output  NREQ  one-hot current owner, zero when no owner.
REQ-011 SHALL have port tx_byte  output  DATA_WIDTH  byte to UART TX FIFO, registered.
REQ-012 SHALL have port transmit  output  1  one-cycle push strobe to UART TX FIFO, registered.
REQ-013 SHALL have port tx_fifo_full  input  1  UART TX FIFO full flag.
REQ-014 SHALL have port timeout_evt  output  1  one-cycle pulse when a lock is forcibly released.

Function
REQ-015 SHALL implement FSM states IDLE, OWN, WAIT.
REQ-016 IDLE: if any req high, SHALL select owner by round-robin starting at (last_owner+1) mod NREQ, set grant, enter OWN next cycle; else stay IDLE, grant=0.
REQ-017 OWN: if req[owner]=1 and tx_fifo_full=0, SHALL register tx_byte<=data[owner], transmit<=1, ack[owner]<=1, last_owner<=owner, enter WAIT.
REQ-018 OWN: if req[owner]=1 and tx_fifo_full=1, SHALL hold in OWN, no push, no ack, grant unchanged (no starvation rotation while full).
REQ-019 OWN: if req[owner]=0 and lock[owner]=0, SHALL set last_owner<=owner, clear grant, enter IDLE.
REQ-020 OWN: if req[owner]=0 and lock[owner]=1, SHALL increment hold counter; when counter reaches TIMEOUT SHALL pulse timeout_evt, clear grant, set last_owner<=owner, enter IDLE.
REQ-021 Hold counter SHALL clear on every push and on every entry to OWN; 8 bits, no wrap (saturating irrelevant as TIMEOUT<=255).
REQ-022 WAIT: exactly one cycle, no push; SHALL go to OWN if lock[owner]=1 else IDLE with grant cleared.
REQ-023 transmit and every ack bit SHALL be high for exactly one cycle (the WAIT cycle); requester SHALL update data/req before the end of the ack cycle.
REQ-024 Latency: req asserted in IDLE -> transmit high 2 cycles later with tx_fifo_full=0; locked back-to-back throughput 1 byte per 2 cycles; unlocked 1 byte per 3 cycles.
REQ-025 Changes to req/lock of non-owners SHALL have no effect until next IDLE arbitration.
REQ-026 Simultaneous req from all requesters SHALL be served in strict rotation, each exactly one byte when lock=0.
REQ-027 grant SHALL always be one-hot or zero; ack SHALL only pulse for the requester granted in the preceding cycle.
REQ-028 tx_byte SHALL hold its last value when transmit=0.

Reset
REQ-029 On rst_n low, asynchronously: state=IDLE, grant=0, ack=0, transmit=0, tx_byte=0, timeout_evt=0, hold counter=0, last_owner=NREQ-1 (requester 0 wins first).
REQ-030 Reset asserted mid-transfer SHALL discard any pending push; no transmit pulse after rst_n deasserts until a new arbitration.

Verification
REQ-031 req=4'b1111, lock=0, data bytes 0x10,0x11,0x12,0x13 -> transmit pulses with tx_byte 0x10,0x11,0x12,0x13 in order, 3 cycles apart, ack 0001,0010,0100,1000.
REQ-032 req[2]=1, lock[2]=1 for 4 bytes 0xA0..0xA3 while req[0]=1 -> four pushes 2 cycles apart from requester 2 before any grant to requester 0.
REQ-033 Owner req high, tx_fifo_full=1 for 10 cycles then 0 -> no transmit during full, single push on the cycle after full drops (visible 1 cycle later).
REQ-034 TIMEOUT=5, owner lock=1, req=0 -> timeout_evt pulses after 5 OWN cycles, grant clears, next requester granted.
REQ-035 rst_n low during WAIT of a push -> all outputs 0 immediately, first post-reset grant goes to requester 0.
